// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, digit width and helpers for bin2bcd_seq
package bin2bcd_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_cell.sv
// bcd_digit_cell: one BCD digit of the double-dabble chain, add-3 then shift
module bcd_digit_cell
  import bin2bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             si_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             so_o
);
  logic [BCD_W-1:0] digit_q, digit_d, adj;
  assign adj = add3(digit_q);
  assign so_o = adj[BCD_W-1];
  assign digit_o = digit_q;
  always_comb digit_d = clr_i ? '0 : en_i ? {adj[BCD_W-2:0], si_i} : digit_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit_q <= '0;
    else digit_q <= digit_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter, one bit per clock,
// with optional signed input, overflow flag and leading-zero mask
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIN_W-1:0]        in_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    sign,
  output logic                    ovf,
  output logic [DIGITS-1:0]       lz_mask
);
  localparam int CW = clog2(BIN_W);
  state_e state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, ovf_q, ovf_d, in_ready_q, out_valid_q, cap, sh, last, neg, z;
  logic [DIGITS-1:0] lz_q, lz_d;
  logic [DIGITS:0] chain;
  logic [BCD_W*DIGITS-1:0] nxt;
  assign cap = (state_q == IDLE) && in_valid;
  assign sh = (state_q == SHIFT);
  assign last = sh && (cnt_q == '0);
  assign neg = (SIGNED != 0) && in_bin[BIN_W-1];
  assign chain[0] = sr_q[BIN_W-1];
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      logic [BCD_W-1:0] adj;
      bcd_digit_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cap),
        .en_i    (sh),
        .si_i    (chain[k]),
        .digit_o (bcd[BCD_W*k +: BCD_W]),
        .so_o    (chain[k+1])
      );
      // digit value after this cycle's shift, so the mask lands with bcd
      assign adj = add3(bcd[BCD_W*k +: BCD_W]);
      assign nxt[BCD_W*k +: BCD_W] = {adj[BCD_W-2:0], chain[k]};
    end
  endgenerate
  always_comb begin
    lz_d = lz_q;
    z = 1'b1;
    if (last) begin
      lz_d = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        z = z & ~|nxt[BCD_W*i +: BCD_W];
        lz_d[i] = z;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    sign_d = sign_q;
    ovf_d = ovf_q;
    if (cap) begin
      sr_d = neg ? -in_bin : in_bin;
      sign_d = neg;
      ovf_d = 1'b0;
      cnt_d = CW'(BIN_W - 1);
      state_d = SHIFT;
    end else if (sh) begin
      sr_d = sr_q << 1;
      ovf_d = ovf_q | chain[DIGITS];
      cnt_d = last ? cnt_q : cnt_q - 1'b1;
      state_d = last ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
      lz_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      sign_q <= sign_d;
      ovf_q <= ovf_d;
      lz_q <= lz_d;
      in_ready_q <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign sign = sign_q;
  assign ovf = ovf_q;
  assign lz_mask = lz_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench driving default, 5-digit and signed converters in lockstep
module tb_bin2bcd_seq;
  typedef struct {logic [27:0] bcd; logic sign; logic ovf; logic [6:0] lz;} exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [19:0] in_bin = '0;
  logic in_ready0, in_ready1, in_ready2, out_valid0, out_valid1, out_valid2;
  logic [27:0] bcd0, bcd2;
  logic [19:0] bcd1;
  logic sign0, sign1, sign2, ovf0, ovf1, ovf2, ovp = 0;
  logic [6:0] lz0, lz2;
  logic [4:0] lz1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  exp_t q0[$], q1[$], q2[$];
  int acc0[$];

  bin2bcd_seq dut0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_bin(in_bin),
    .out_valid(out_valid0), .out_ready(out_ready), .bcd(bcd0), .sign(sign0), .ovf(ovf0), .lz_mask(lz0));
  bin2bcd_seq #(.DIGITS(5)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_bin(in_bin),
    .out_valid(out_valid1), .out_ready(out_ready), .bcd(bcd1), .sign(sign1), .ovf(ovf1), .lz_mask(lz1));
  bin2bcd_seq #(.SIGNED(1)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_bin(in_bin),
    .out_valid(out_valid2), .out_ready(out_ready), .bcd(bcd2), .sign(sign2), .ovf(ovf2), .lz_mask(lz2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [19:0] v, input int dig, input bit sg);
    exp_t e;
    logic [19:0] m;
    longint unsigned mm, p;
    bit z;
    e.sign = sg && v[19];
    m = e.sign ? (~v + 20'd1) : v;
    p = 1;
    for (int k = 0; k < dig; k++) p = p * 10;
    mm = longint'(m);
    e.ovf = (mm >= p);
    mm = mm % p;
    e.bcd = '0;
    for (int k = 0; k < dig; k++) begin
      e.bcd[4*k +: 4] = 4'(mm % 10);
      mm = mm / 10;
    end
    e.lz = '0;
    z = 1;
    for (int k = dig - 1; k >= 1; k--) begin
      z = z && (e.bcd[4*k +: 4] == 4'd0);
      e.lz[k] = z;
    end
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input logic [27:0] b, input logic s, input logic o,
                       input logic [6:0] l);
    chk({tag, "_bcd"}, {4'd0, b}, {4'd0, e.bcd});
    chk({tag, "_sign"}, {31'd0, s}, {31'd0, e.sign});
    chk({tag, "_ovf"}, {31'd0, o}, {31'd0, e.ovf});
    chk({tag, "_lz"}, {25'd0, l}, {25'd0, e.lz});
  endtask

  always @(negedge clk)
    if (rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) chk("d0_unexpected", 1, 0);
      else score("d0", q0.pop_front(), bcd0, sign0, ovf0, lz0);
    end
  always @(negedge clk)
    if (rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("d1_unexpected", 1, 0);
      else score("d1", q1.pop_front(), {8'd0, bcd1}, sign1, ovf1, {2'd0, lz1});
    end
  always @(negedge clk)
    if (rst_n && out_valid2 && out_ready) begin
      if (q2.size() == 0) chk("d2_unexpected", 1, 0);
      else score("d2", q2.pop_front(), bcd2, sign2, ovf2, lz2);
    end
  always @(negedge clk) begin
    if (rst_n && out_valid0 && !ovp) begin
      if (acc0.size() == 0) chk("lat_unexpected", 1, 0);
      else chk("latency", cyc - acc0.pop_front(), 20);
    end
    ovp <= out_valid0;
  end

  task automatic send(input logic [19:0] v);
    int n = 0;
    @(negedge clk);
    in_bin = v;
    in_valid = 1;
    while (!in_ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) chk("accept_timeout", 0, 1);
    else begin
      q0.push_back(model(v, 7, 0));
      q1.push_back(model(v, 5, 0));
      q2.push_back(model(v, 7, 1));
      acc0.push_back(cyc + 1);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] vals[8] = '{20'd0, 20'd1048575, 20'd123456, 20'h80000, 20'd9, 20'd10, 20'h7FFFF, 20'd99999};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_bcd", bcd0, 0);
    chk("rst_flags", {sign0, ovf0, lz0}, 0);
    chk("rst_d2_flags", {sign2, ovf2, lz2}, 0);
    rst_n = 1;
    foreach (vals[i]) send(vals[i]);
    repeat (6) send(20'($urandom_range(0, 20'hFFFFF)));
    drain();

    out_ready = 0;
    send(20'd42);
    in_valid = 1;
    in_bin = 20'd777;
    for (int n = 0; n < 100 && !out_valid0; n++) @(negedge clk);
    chk("bp_out_valid", out_valid0, 1);
    repeat (5) begin
      chk("bp_in_ready", in_ready0, 0);
      chk("bp_bcd_hold", bcd0, 28'h0000042);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(20'd777);
    drain();

    send(20'd555555);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    q0.delete(); q1.delete(); q2.delete(); acc0.delete();
    #1;
    chk("abort_bcd", bcd0, 0);
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_in_ready", in_ready0, 1);
    chk("abort_flags", {sign0, ovf0, lz0}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("post_rst_in_ready", in_ready0, 1);
    chk("post_rst_out_valid", out_valid0, 0);
    send(20'd99999);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
